// File: rtl/issue_arbiter.sv
// Issue arbiter: picks one requesting decode slot per cycle and registers a one-hot
// execute enable plus the winner's writeback tag. Fixed priority (with optional
// starvation promotion) or round-robin.
module issue_arbiter #(
  parameter int N            = 2,
  parameter int RR           = 0,
  parameter int STARVE_LIMIT = 0,
  localparam int IW          = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_we,
  input  logic          i_stall,
  output logic [N-1:0]  o_ce,
  output logic          o_we,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_valid
);
  localparam bit STARVE_EN      = (RR == 0) && (STARVE_LIMIT > 0);
  localparam int CW             = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [N-1:0]         ce_q, ce_d;
  logic                 we_q, we_d;
  logic [IW-1:0]        gnt_q, gnt_d;
  logic                 vld_q, vld_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [N-1:0][CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  starved;
  logic [IW-1:0] win;
  logic [IW-1:0] ridx;
  logic          found;
  logic          any_req;

  assign any_req = |i_req;

  always_comb begin
    for (int i = 0; i < N; i++)
      starved[i] = STARVE_EN && i_req[i] && (cnt_q[i] == LIM);
  end

  // Winner select; downward loops leave the lowest matching index in win.
  always_comb begin
    win   = '0;
    ridx  = '0;
    found = 1'b0;
    if (RR != 0) begin
      for (int k = 0; k < N; k++) begin
        ridx = IW'((int'(ptr_q) + k) % N);
        if (!found && i_req[ridx]) begin
          win   = ridx;
          found = 1'b1;
        end
      end
    end else if (|starved) begin
      for (int i = N - 1; i >= 0; i--)
        if (starved[i]) win = IW'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (i_req[i]) win = IW'(i);
    end
  end

  always_comb begin
    ce_d  = '0;
    we_d  = 1'b0;
    gnt_d = '0;
    vld_d = 1'b0;
    ptr_d = ptr_q;
    if (any_req) begin
      ce_d[win] = 1'b1;
      we_d      = i_we[win];
      gnt_d     = win;
      vld_d     = 1'b1;
      if (RR != 0) ptr_d = (win == IW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

  // A slot only ages while it keeps requesting and keeps losing.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (STARVE_EN && i_req[i] && (win != IW'(i)))
        cnt_d[i] = (cnt_q[i] == LIM) ? LIM : cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ce_q  <= '0;
      we_q  <= 1'b0;
      gnt_q <= '0;
      vld_q <= 1'b0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (!i_stall) begin
      ce_q  <= ce_d;
      we_q  <= we_d;
      gnt_q <= gnt_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_ce      = ce_q;
  assign o_we      = we_q;
  assign o_gnt_idx = gnt_q;
  assign o_valid   = vld_q;
endmodule

// File: tb/tb_issue_arbiter.sv
// Directed bench for issue_arbiter: three instances cover fixed priority,
// round-robin and starvation promotion against hand-computed expectations.
module tb_issue_arbiter;
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Fixed priority, N=2
  logic       f_rst, f_stall;
  logic [1:0] f_req, f_we, f_ce;
  logic       f_owe, f_gnt, f_vld;
  // Round-robin, N=4
  logic       r_rst, r_stall;
  logic [3:0] r_req, r_we, r_ce;
  logic       r_owe, r_vld;
  logic [1:0] r_gnt;
  // Fixed with starvation promotion, N=2, limit 3
  logic       s_rst, s_stall;
  logic [1:0] s_req, s_we, s_ce;
  logic       s_owe, s_gnt, s_vld;

  issue_arbiter #(.N(2), .RR(0), .STARVE_LIMIT(0)) u_fix (
    .i_clk(i_clk), .i_rst(f_rst), .i_req(f_req), .i_we(f_we), .i_stall(f_stall),
    .o_ce(f_ce), .o_we(f_owe), .o_gnt_idx(f_gnt), .o_valid(f_vld));

  issue_arbiter #(.N(4), .RR(1), .STARVE_LIMIT(0)) u_rr (
    .i_clk(i_clk), .i_rst(r_rst), .i_req(r_req), .i_we(r_we), .i_stall(r_stall),
    .o_ce(r_ce), .o_we(r_owe), .o_gnt_idx(r_gnt), .o_valid(r_vld));

  issue_arbiter #(.N(2), .RR(0), .STARVE_LIMIT(3)) u_stv (
    .i_clk(i_clk), .i_rst(s_rst), .i_req(s_req), .i_we(s_we), .i_stall(s_stall),
    .o_ce(s_ce), .o_we(s_owe), .o_gnt_idx(s_gnt), .o_valid(s_vld));

  // Inputs change 1ns after an edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    f_rst = 1; f_stall = 1; f_req = '1; f_we = '1;
    r_rst = 1; r_stall = 1; r_req = '1; r_we = '1;
    s_rst = 1; s_stall = 1; s_req = '1; s_we = '1;
    step();
    n_vec++;
    if ({f_ce, f_owe, f_gnt, f_vld} !== 5'b0) begin
      n_err++; $display("FAIL reset_fix got %b exp 00000", {f_ce, f_owe, f_gnt, f_vld});
    end
    n_vec++;
    if ({r_ce, r_owe, r_gnt, r_vld} !== 8'b0) begin
      n_err++; $display("FAIL reset_rr got %b exp 00000000", {r_ce, r_owe, r_gnt, r_vld});
    end
    n_vec++;
    if ({s_ce, s_owe, s_gnt, s_vld} !== 5'b0) begin
      n_err++; $display("FAIL reset_stv got %b exp 00000", {s_ce, s_owe, s_gnt, s_vld});
    end
    f_rst = 0; f_stall = 0; f_req = '0; f_we = '0;
    r_rst = 0; r_stall = 0; r_req = '0; r_we = '0;
    s_rst = 0; s_stall = 0; s_req = '0; s_we = '0;
  endtask

  task automatic test_fixed();
    // {ce, we, gnt, valid} after each edge
    logic [1:0] req_t [4] = '{2'b11, 2'b10, 2'b00, 2'b11};
    logic [1:0] we_t  [4] = '{2'b10, 2'b10, 2'b11, 2'b01};
    logic [4:0] exp_t [4] = '{5'b01_0_0_1, 5'b10_1_1_1, 5'b00_0_0_0, 5'b01_1_0_1};
    for (int i = 0; i < 4; i++) begin
      f_req = req_t[i]; f_we = we_t[i];
      step();
      n_vec++;
      if ({f_ce, f_owe, f_gnt, f_vld} !== exp_t[i]) begin
        n_err++;
        $display("FAIL fixed[%0d] got {ce,we,gnt,vld}=%b exp %b", i, {f_ce, f_owe, f_gnt, f_vld}, exp_t[i]);
      end
    end
    f_req = '0;
  endtask

  task automatic test_rr_rotate();
    logic [3:0] exp_t [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] idx_t [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    r_rst = 1; step(); r_rst = 0;
    r_req = 4'b1111; r_we = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (r_ce !== exp_t[i] || r_gnt !== idx_t[i] || r_vld !== 1'b1 || r_owe !== ~idx_t[i][0]) begin
        n_err++;
        $display("FAIL rr_rotate[%0d] got ce=%b gnt=%0d vld=%b we=%b exp ce=%b gnt=%0d vld=1 we=%b",
                 i, r_ce, r_gnt, r_vld, r_owe, exp_t[i], idx_t[i], ~idx_t[i][0]);
      end
    end
    r_req = '0;
  endtask

  task automatic test_rr_wrap();
    logic [3:0] req_t [3] = '{4'b0100, 4'b0011, 4'b0011};
    logic [3:0] exp_t [3] = '{4'b0100, 4'b0001, 4'b0010};
    r_rst = 1; step(); r_rst = 0;
    for (int i = 0; i < 3; i++) begin
      r_req = req_t[i];
      step();
      n_vec++;
      if (r_ce !== exp_t[i]) begin
        n_err++; $display("FAIL rr_wrap[%0d] got ce=%b exp %b", i, r_ce, exp_t[i]);
      end
    end
    // idle cycle must not move the pointer (p=2 now)
    r_req = 4'b0000; step();
    n_vec++;
    if (r_vld !== 1'b0 || r_ce !== 4'b0) begin
      n_err++; $display("FAIL rr_idle got ce=%b vld=%b exp ce=0000 vld=0", r_ce, r_vld);
    end
    r_req = 4'b1011; step();
    n_vec++;
    if (r_ce !== 4'b1000) begin
      n_err++; $display("FAIL rr_after_idle got ce=%b exp 1000", r_ce);
    end
    r_req = '0;
  endtask

  task automatic test_starvation();
    logic [1:0] exp_t [8] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
    s_rst = 1; step(); s_rst = 0;
    s_req = 2'b11; s_we = 2'b10;
    for (int i = 0; i < 8; i++) begin
      step();
      n_vec++;
      if (s_ce !== exp_t[i] || s_owe !== exp_t[i][1] || s_gnt !== exp_t[i][1]) begin
        n_err++;
        $display("FAIL starve[%0d] got ce=%b we=%b gnt=%0d exp ce=%b", i, s_ce, s_owe, s_gnt, exp_t[i]);
      end
    end
    // dropping the request clears slot 1's age: three more wins for slot 0 follow
    s_req = 2'b01; step();
    s_req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (s_ce !== 2'b01) begin
        n_err++; $display("FAIL starve_clear[%0d] got ce=%b exp 01", i, s_ce);
      end
    end
    s_req = '0;
  endtask

  task automatic test_stall();
    r_rst = 1; step(); r_rst = 0;
    r_req = 4'b1111; r_we = 4'b0010;
    step(); step();
    n_vec++;
    if (r_ce !== 4'b0010 || r_owe !== 1'b1) begin
      n_err++; $display("FAIL stall_setup got ce=%b we=%b exp ce=0010 we=1", r_ce, r_owe);
    end
    r_stall = 1;
    for (int i = 0; i < 3; i++) begin
      r_req = (i == 1) ? 4'b0001 : 4'b1111;
      r_we  = 4'b0000;
      step();
      n_vec++;
      if (r_ce !== 4'b0010 || r_gnt !== 2'd1 || r_vld !== 1'b1 || r_owe !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold[%0d] got ce=%b gnt=%0d vld=%b we=%b exp ce=0010 gnt=1 vld=1 we=1",
                 i, r_ce, r_gnt, r_vld, r_owe);
      end
    end
    r_stall = 0; r_req = 4'b1111;
    step();
    n_vec++;
    if (r_ce !== 4'b0100 || r_gnt !== 2'd2) begin
      n_err++; $display("FAIL stall_release got ce=%b gnt=%0d exp ce=0100 gnt=2", r_ce, r_gnt);
    end
  endtask

  task automatic test_stall_reset();
    r_stall = 1; r_req = 4'b1111; r_we = 4'b1111;
    step();
    r_rst = 1;
    step();
    n_vec++;
    if ({r_ce, r_owe, r_gnt, r_vld} !== 8'b0) begin
      n_err++; $display("FAIL stall_reset got %b exp 00000000", {r_ce, r_owe, r_gnt, r_vld});
    end
    r_rst = 0; r_stall = 0;
    step();
    n_vec++;
    if (r_ce !== 4'b0001) begin
      n_err++; $display("FAIL ptr_after_reset got ce=%b exp 0001", r_ce);
    end
    r_req = '0;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_rotate();
    test_rr_wrap();
    test_starvation();
    test_stall();
    test_stall_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
